pipe_stage_reg: RTL

- Parametrised pipeline stage register for the RISC-V core. It generalises the fixed-width, always-load ID/EX latch.
- Adds valid/ready handshaking, stall hold and flush-to-bubble, with optional skid buffering.
- One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Each instance carries saturating stall and flush counters for performance debug.

---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/pipe_stage_reg_sat_counter.sv | 25 ++
 rtl/pipe_stage_reg.sv | 105 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: stage bundle widths, ID/EX field layout and the default bubble.
package pipe_pkg;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 183;
    localparam int EX_MEM_W = 107;
    localparam int MEM_WB_W = 71;

    // ID/EX bit offsets (LSB of each field), listed MSB to LSB.
    localparam int ROTATE_SIGNAL_O = 182;
    localparam int PC_4_O          = 150;
    localparam int PC_O            = 118;
    localparam int MUX_COMPLMNT_O  = 117;
    localparam int MUX_INP_2_O     = 116;
    localparam int MUX_INP_1_O     = 115;
    localparam int MUX_D_MEM_O     = 114;
    localparam int WRITE_REG_EN_O  = 113;
    localparam int WRITE_ADDRESS_O = 108;
    localparam int D_MEM_R_O       = 107;
    localparam int D_MEM_W_O       = 106;
    localparam int BRANCH_O        = 105;
    localparam int JUMP_O          = 104;
    localparam int ALU_OP_O        = 101;
    localparam int FUN_3_O         = 98;
    localparam int MUX_RESULT_O    = 96;
    localparam int DATA_1_O        = 64;
    localparam int DATA_2_O        = 32;
    localparam int MUX_1_OUT_O     = 0;

    typedef struct packed {
        logic        rotate_signal;
        logic [31:0] pc_4;
        logic [31:0] pc;
        logic        mux_complmnt;
        logic        mux_inp_2;
        logic        mux_inp_1;
        logic        mux_d_mem;
        logic        write_reg_en;
        logic [4:0]  write_address;
        logic        d_mem_r;
        logic        d_mem_w;
        logic        branch;
        logic        jump;
        logic [2:0]  alu_op;
        logic [2:0]  fun_3;
        logic [1:0]  mux_result;
        logic [31:0] data_1;
        logic [31:0] data_2;
        logic [31:0] mux_1_out;
    } id_ex_t;

    // All-zero decodes as a NOP: no register write, no memory access.
    localparam logic [ID_EX_W-1:0] ID_EX_BUBBLE = '0;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for per-stage stall/flush performance statistics.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + ONE;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready, stall hold, flush-to-bubble and perf counters.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer that registers in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = ID_EX_W,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             stall,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;
    logic             in_fire;
    logic             out_fire;
    logic             stall_inc;

    // A stalled stage still holds its instruction but must not hand it on.
    assign out_valid = valid_reg & ~stall;
    assign out_data  = data_reg;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] skid_data_reg;
    logic             skid_valid_reg;

    assign in_ready = ~skid_valid_reg & ~stall;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            data_reg       <= BUBBLE;
            valid_reg      <= 1'b0;
            skid_data_reg  <= BUBBLE;
            skid_valid_reg <= 1'b0;
        end else if (!stall) begin
            if (out_fire) begin
                if (skid_valid_reg) begin
                    data_reg       <= skid_data_reg;
                    skid_valid_reg <= 1'b0;
                end else if (in_fire) begin
                    data_reg <= in_data;
                end else begin
                    valid_reg <= 1'b0;
                end
            end else if (in_fire) begin
                // Main entry is occupied and not draining: park the payload.
                if (valid_reg) begin
                    skid_data_reg  <= in_data;
                    skid_valid_reg <= 1'b1;
                end else begin
                    data_reg  <= in_data;
                    valid_reg <= 1'b1;
                end
            end
        end
    end
`else
    assign in_ready = ~stall & (~valid_reg | out_ready);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            data_reg  <= BUBBLE;
            valid_reg <= 1'b0;
        end else if (!stall) begin
            if (in_fire) begin
                data_reg  <= in_data;
                valid_reg <= 1'b1;
            end else if (out_fire) begin
                valid_reg <= 1'b0;
            end
        end
    end
`endif

    // Stall and backpressure share one increment so a cycle is counted once.
    assign stall_inc = ~flush & (stall | (valid_reg & ~out_ready));

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush),
        .count (flush_cnt)
    );

endmodule
